// File: rtl/mips_check_pkg.sv
// mips_check_pkg
// Shared types and constants for the end-of-run result checker:
//   - FSM state encoding (RUN, SCAN, DONE)
//   - data-word category encoding and the word-index -> category map
//   - scoreboard counter widths and the count each category needs to pass
package mips_check_pkg;

    localparam int IDX_W     = 5;
    localparam int CNT_W     = 3;
    localparam int SLT_CNT_W = 2;

    typedef enum logic [1:0] {
        RUN,
        SCAN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        CAT_NONE,
        LDST,
        ADD,
        SUB,
        SLT,
        BEQ,
        BNE
    } cat_t;

    // Number of reference words in each category; every one must match to pass.
    localparam logic [CNT_W-1:0]     EXP_LDST = 3'd3;
    localparam logic [CNT_W-1:0]     EXP_ADD  = 3'd4;
    localparam logic [CNT_W-1:0]     EXP_SUB  = 3'd4;
    localparam logic [CNT_W-1:0]     EXP_BEQ  = 3'd4;
    localparam logic [SLT_CNT_W-1:0] EXP_SLT  = 2'd2;
    localparam logic [CNT_W-1:0]     EXP_BNE  = 3'd1;

    // Which instruction category produced the data word at a given index.
    // Indices not written by the test program are left uncategorized.
    function automatic cat_t idx_to_cat(input logic [IDX_W-1:0] idx);
        cat_t cat;
        case (idx)
            5'd3, 5'd4, 5'd6:              cat = LDST;
            5'd7, 5'd8, 5'd9, 5'd10:       cat = ADD;
            5'd11, 5'd12, 5'd13, 5'd14:    cat = BEQ;
            5'd15, 5'd16, 5'd17, 5'd18:    cat = SUB;
            5'd19, 5'd20:                  cat = SLT;
            5'd21:                         cat = BNE;
            default:                       cat = CAT_NONE;
        endcase
        return cat;
    endfunction

endpackage

// File: rtl/mips_result_checker_halt_detector.sv
// halt_detector
// Watches the fetched instruction stream while the CPU runs and flags the
// edge on which the run should end.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   en            count only while high (checker in RUN)
//   inst          instruction currently fetched
//   scan_start    combinational: this edge ends the run (NOP run or watchdog)
//   wd_only       combinational: this edge ends the run by watchdog alone
module halt_detector
    #(
        parameter int TIMEOUT  = 9,
        parameter int WATCHDOG = 500
    )
    (
        input  logic        clk,
        input  logic        rst,
        input  logic        en,
        input  logic [31:0] inst,
        output logic        scan_start,
        output logic        wd_only
    );

    localparam int NOP_W = $clog2(TIMEOUT + 1);
    localparam int WD_W  = $clog2(WATCHDOG + 1);

    logic [NOP_W-1:0] nop_cnt_q, nop_cnt_d;
    logic [WD_W-1:0]  watch_cnt_q, watch_cnt_d;
    logic             nop_hit;
    logic             wd_hit;

    // Both triggers look at the updated counts so the run ends on the very
    // edge where the limit is reached.
    always_comb begin
        nop_cnt_d   = nop_cnt_q;
        watch_cnt_d = watch_cnt_q;
        if (en) begin
            nop_cnt_d   = (inst == 32'd0) ? nop_cnt_q + NOP_W'(1) : '0;
            watch_cnt_d = watch_cnt_q + WD_W'(1);
        end
        nop_hit    = en && (nop_cnt_d == NOP_W'(TIMEOUT));
        wd_hit     = en && (watch_cnt_d == WD_W'(WATCHDOG));
        scan_start = nop_hit || wd_hit;
        wd_only    = wd_hit && !nop_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nop_cnt_q   <= '0;
            watch_cnt_q <= '0;
        end else begin
            nop_cnt_q   <= nop_cnt_d;
            watch_cnt_q <= watch_cnt_d;
        end
    end

endmodule

// File: rtl/mips_result_checker.sv
// mips_result_checker
// End-of-run checker for single_cycle_mips. Detects halt (NOP run) or
// watchdog expiry, freezes the CPU, sweeps data memory one word per cycle
// against a reference ROM and counts matches per instruction category.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   inst                      fetched instruction (used only in RUN)
//   cpu_hold                  CPU clock-enable must be low while set
//   mem_addr / mem_rdata      data-memory read port (byte address idx*4)
//   ref_idx / ref_rdata       reference ROM read port
//   cnt_*                     per-category match counts (saturating)
//   done, pass, timed_out     sweep status
//   first_err_idx/_valid      first mismatching categorized word
// Build option: define CHECKER_MISMATCH_LOG_EN to capture the first
// mismatching categorized index; otherwise those outputs are tied to 0.
module mips_result_checker
    import mips_check_pkg::*;
    #(
        parameter int TIMEOUT   = 9,
        parameter int WATCHDOG  = 500,
        parameter int NUM_WORDS = 22
    )
    (
        input  logic                 clk,
        input  logic                 rst,
        input  logic [31:0]          inst,
        output logic                 cpu_hold,
        output logic [31:0]          mem_addr,
        input  logic [31:0]          mem_rdata,
        output logic [IDX_W-1:0]     ref_idx,
        input  logic [31:0]          ref_rdata,
        output logic [CNT_W-1:0]     cnt_ldst,
        output logic [CNT_W-1:0]     cnt_add,
        output logic [CNT_W-1:0]     cnt_sub,
        output logic [SLT_CNT_W-1:0] cnt_slt,
        output logic [CNT_W-1:0]     cnt_beq,
        output logic [CNT_W-1:0]     cnt_bne,
        output logic                 done,
        output logic                 timed_out,
        output logic                 pass,
        output logic [IDX_W-1:0]     first_err_idx,
        output logic                 first_err_valid
    );

    localparam logic [CNT_W-1:0]     CNT_MAX = '1;
    localparam logic [SLT_CNT_W-1:0] SLT_MAX = '1;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     ldst_q, ldst_d, add_q, add_d, sub_q, sub_d;
    logic [CNT_W-1:0]     beq_q, beq_d, bne_q, bne_d;
    logic [SLT_CNT_W-1:0] slt_q, slt_d;
    logic                 timed_out_q, timed_out_d;
    logic                 scan_start;
    logic                 wd_only;
    logic                 word_match;
    cat_t                 cur_cat;

    halt_detector #(
        .TIMEOUT  (TIMEOUT),
        .WATCHDOG (WATCHDOG)
    ) u_halt (
        .clk        (clk),
        .rst        (rst),
        .en         (state_q == RUN),
        .inst       (inst),
        .scan_start (scan_start),
        .wd_only    (wd_only)
    );

    assign cur_cat    = idx_to_cat(idx_q);
    assign word_match = (mem_rdata == ref_rdata);

    // Next-state, scan index and scoreboard. Counters hold outside SCAN and
    // stop at full scale instead of wrapping.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ldst_d      = ldst_q;
        add_d       = add_q;
        sub_d       = sub_q;
        slt_d       = slt_q;
        beq_d       = beq_q;
        bne_d       = bne_q;
        timed_out_d = timed_out_q;
        case (state_q)
            RUN: begin
                if (scan_start) begin
                    state_d     = SCAN;
                    idx_d       = '0;
                    timed_out_d = wd_only;
                end
            end
            SCAN: begin
                if (word_match) begin
                    case (cur_cat)
                        LDST: if (ldst_q != CNT_MAX) ldst_d = ldst_q + 3'd1;
                        ADD:  if (add_q  != CNT_MAX) add_d  = add_q  + 3'd1;
                        SUB:  if (sub_q  != CNT_MAX) sub_d  = sub_q  + 3'd1;
                        SLT:  if (slt_q  != SLT_MAX) slt_d  = slt_q  + 2'd1;
                        BEQ:  if (beq_q  != CNT_MAX) beq_d  = beq_q  + 3'd1;
                        BNE:  if (bne_q  != CNT_MAX) bne_d  = bne_q  + 3'd1;
                        default: ;
                    endcase
                end
                if (idx_q == IDX_W'(NUM_WORDS - 1)) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: ;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            idx_q       <= '0;
            ldst_q      <= '0;
            add_q       <= '0;
            sub_q       <= '0;
            slt_q       <= '0;
            beq_q       <= '0;
            bne_q       <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ldst_q      <= ldst_d;
            add_q       <= add_d;
            sub_q       <= sub_d;
            slt_q       <= slt_d;
            beq_q       <= beq_d;
            bne_q       <= bne_d;
            timed_out_q <= timed_out_d;
        end
    end

`ifdef CHECKER_MISMATCH_LOG_EN
    logic [IDX_W-1:0] err_idx_q, err_idx_d;
    logic             err_valid_q, err_valid_d;

    // Only the first mismatching categorized word is latched.
    always_comb begin
        err_idx_d   = err_idx_q;
        err_valid_d = err_valid_q;
        if ((state_q == SCAN) && (cur_cat != CAT_NONE) && !word_match && !err_valid_q) begin
            err_idx_d   = idx_q;
            err_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_idx_q   <= '0;
            err_valid_q <= 1'b0;
        end else begin
            err_idx_q   <= err_idx_d;
            err_valid_q <= err_valid_d;
        end
    end

    assign first_err_idx   = err_idx_q;
    assign first_err_valid = err_valid_q;
`else
    assign first_err_idx   = '0;
    assign first_err_valid = 1'b0;
`endif

    assign cpu_hold  = (state_q != RUN);
    assign mem_addr  = (state_q == SCAN) ? {{(32 - IDX_W - 2){1'b0}}, idx_q, 2'b00} : 32'd0;
    assign ref_idx   = idx_q;
    assign cnt_ldst  = ldst_q;
    assign cnt_add   = add_q;
    assign cnt_sub   = sub_q;
    assign cnt_slt   = slt_q;
    assign cnt_beq   = beq_q;
    assign cnt_bne   = bne_q;
    assign done      = (state_q == DONE);
    assign timed_out = timed_out_q;
    assign pass      = (state_q == DONE) &&
                       (ldst_q == EXP_LDST) && (add_q == EXP_ADD) &&
                       (sub_q  == EXP_SUB)  && (slt_q == EXP_SLT) &&
                       (beq_q  == EXP_BEQ)  && (bne_q == EXP_BNE);

endmodule

// File: tb/tb_mips_result_checker.sv
// tb_mips_result_checker
// Directed bench for mips_result_checker: a behavioural data memory and
// reference ROM, NOP-run and watchdog halts, corrupted words and a
// mid-sweep reset, all with hand-computed expected values.
module tb_mips_result_checker;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic        cpu_hold;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [4:0]  ref_idx;
    logic [31:0] ref_rdata;
    logic [2:0]  cnt_ldst, cnt_add, cnt_sub, cnt_beq, cnt_bne;
    logic [1:0]  cnt_slt;
    logic        done, timed_out, pass;
    logic [4:0]  first_err_idx;
    logic        first_err_valid;

    logic [31:0] data_mem [0:21];
    logic [31:0] ref_rom  [0:21];

    int checks = 0;
    int errors = 0;

    mips_result_checker dut (
        .clk             (clk),
        .rst             (rst),
        .inst            (inst),
        .cpu_hold        (cpu_hold),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .ref_idx         (ref_idx),
        .ref_rdata       (ref_rdata),
        .cnt_ldst        (cnt_ldst),
        .cnt_add         (cnt_add),
        .cnt_sub         (cnt_sub),
        .cnt_slt         (cnt_slt),
        .cnt_beq         (cnt_beq),
        .cnt_bne         (cnt_bne),
        .done            (done),
        .timed_out       (timed_out),
        .pass            (pass),
        .first_err_idx   (first_err_idx),
        .first_err_valid (first_err_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational memory and ROM read ports.
    always_comb begin
        mem_rdata = (mem_addr[31:2] < 30'd22) ? data_mem[mem_addr[6:2]] : 32'd0;
        ref_rdata = (ref_idx < 5'd22) ? ref_rom[ref_idx] : 32'd0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive inst and advance the given number of edges; outputs settle 1ns later.
    task automatic applyStimulus(input logic [31:0] value, input int cycles);
        inst = value;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(32'h0, 2);
        rst = 1'b0;
    endtask

    task automatic restoreMemory();
        for (int i = 0; i < 22; i++) begin
            ref_rom[i]  = 32'hA000_0000 + (i * 32'h0101_0101);
            data_mem[i] = ref_rom[i];
        end
    endtask

    task automatic checkCounts(input string tag, input int ldst, input int add, input int sub,
                               input int slt, input int beq, input int bne);
        checkOutput({tag, " cnt_ldst"}, 32'(cnt_ldst), 32'(ldst));
        checkOutput({tag, " cnt_add"},  32'(cnt_add),  32'(add));
        checkOutput({tag, " cnt_sub"},  32'(cnt_sub),  32'(sub));
        checkOutput({tag, " cnt_slt"},  32'(cnt_slt),  32'(slt));
        checkOutput({tag, " cnt_beq"},  32'(cnt_beq),  32'(beq));
        checkOutput({tag, " cnt_bne"},  32'(cnt_bne),  32'(bne));
    endtask

    initial begin
        rst  = 1'b0;
        inst = 32'h0;
        restoreMemory();

        // Reset state
        resetDut();
        checkOutput("rst cpu_hold", 32'(cpu_hold), 32'd0);
        checkOutput("rst mem_addr", mem_addr, 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst pass", 32'(pass), 32'd0);
        checkOutput("rst timed_out", 32'(timed_out), 32'd0);
        checkCounts("rst", 0, 0, 0, 0, 0, 0);

        // Test 1: 5 real instructions then a NOP run, memory matches ROM
        applyStimulus(32'h2008_0001, 5);
        applyStimulus(32'h0, 8);
        checkOutput("t1 hold before 9th nop", 32'(cpu_hold), 32'd0);
        applyStimulus(32'h0, 1);
        checkOutput("t1 hold on 9th nop", 32'(cpu_hold), 32'd1);
        checkOutput("t1 scan addr0", mem_addr, 32'd0);
        applyStimulus(32'h0, 3);
        checkOutput("t1 scan addr3", mem_addr, 32'd12);
        checkOutput("t1 ref_idx3", 32'(ref_idx), 32'd3);
        applyStimulus(32'h0, 18);
        checkOutput("t1 done early", 32'(done), 32'd0);
        applyStimulus(32'h0, 1);
        checkOutput("t1 done", 32'(done), 32'd1);
        checkOutput("t1 pass", 32'(pass), 32'd1);
        checkOutput("t1 timed_out", 32'(timed_out), 32'd0);
        checkOutput("t1 addr in done", mem_addr, 32'd0);
        checkOutput("t1 err_valid", 32'(first_err_valid), 32'd0);
        checkCounts("t1", 3, 4, 4, 2, 4, 1);
        applyStimulus(32'h2008_0001, 5);
        checkOutput("t1 done held", 32'(done), 32'd1);

        // Test 2: no NOPs ever, watchdog forces the sweep
        resetDut();
        applyStimulus(32'h0109_5020, 499);
        checkOutput("t2 hold at 499", 32'(cpu_hold), 32'd0);
        applyStimulus(32'h0109_5020, 1);
        checkOutput("t2 hold at 500", 32'(cpu_hold), 32'd1);
        checkOutput("t2 timed_out", 32'(timed_out), 32'd1);
        applyStimulus(32'h0109_5020, 22);
        checkOutput("t2 done", 32'(done), 32'd1);
        checkOutput("t2 pass", 32'(pass), 32'd1);

        // Test 3: an interrupted NOP run must not halt
        resetDut();
        applyStimulus(32'h0, 8);
        applyStimulus(32'h1000_FFFF, 1);
        applyStimulus(32'h0, 8);
        checkOutput("t3 hold after 8+8", 32'(cpu_hold), 32'd0);
        applyStimulus(32'h0, 1);
        checkOutput("t3 hold on 9th", 32'(cpu_hold), 32'd1);
        applyStimulus(32'h0, 22);
        checkOutput("t3 done", 32'(done), 32'd1);
        checkOutput("t3 timed_out", 32'(timed_out), 32'd0);

        // Test 4: one ADD word and one SLT word corrupted
        data_mem[8]  = data_mem[8] ^ 32'h0000_0001;
        data_mem[20] = data_mem[20] ^ 32'h8000_0000;
        resetDut();
        applyStimulus(32'h0, 9 + 22);
        checkOutput("t4 done", 32'(done), 32'd1);
        checkOutput("t4 pass", 32'(pass), 32'd0);
        checkCounts("t4", 3, 3, 4, 1, 4, 1);
`ifdef CHECKER_MISMATCH_LOG_EN
        checkOutput("t4 err_idx", 32'(first_err_idx), 32'd8);
        checkOutput("t4 err_valid", 32'(first_err_valid), 32'd1);
`else
        checkOutput("t4 err_idx", 32'(first_err_idx), 32'd0);
        checkOutput("t4 err_valid", 32'(first_err_valid), 32'd0);
`endif
        restoreMemory();

        // Test 5: only uncategorized words corrupted
        data_mem[0] = 32'hDEAD_BEEF;
        data_mem[1] = 32'h0;
        data_mem[2] = 32'hFFFF_FFFF;
        data_mem[5] = 32'h1234_5678;
        resetDut();
        checkOutput("t5 err_valid cleared", 32'(first_err_valid), 32'd0);
        applyStimulus(32'h0, 9 + 22);
        checkOutput("t5 done", 32'(done), 32'd1);
        checkOutput("t5 pass", 32'(pass), 32'd1);
        checkOutput("t5 err_valid", 32'(first_err_valid), 32'd0);
        checkCounts("t5", 3, 4, 4, 2, 4, 1);
        restoreMemory();

        // Test 6: reset in the middle of the sweep
        resetDut();
        applyStimulus(32'h0, 9 + 10);
        checkOutput("t6 addr idx10", mem_addr, 32'd40);
        checkOutput("t6 add before rst", 32'(cnt_add), 32'd3);
        checkOutput("t6 ldst before rst", 32'(cnt_ldst), 32'd3);
        rst = 1'b1;
        applyStimulus(32'h0, 1);
        checkOutput("t6 hold", 32'(cpu_hold), 32'd0);
        checkOutput("t6 addr", mem_addr, 32'd0);
        checkOutput("t6 done", 32'(done), 32'd0);
        checkCounts("t6", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        applyStimulus(32'h2008_0001, 2);
        checkOutput("t6 running again", 32'(cpu_hold), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_result_checker.md
Name: mips_result_checker

Overview:
Synthesizable end-of-run checker placed downstream of single_cycle_mips and its data memory. It monitors the fetched instruction stream and detects program halt (a run of consecutive NOPs) or a watchdog expiry. It then freezes the CPU, sweeps the data memory through a read port, and compares each word against an external reference ROM. It reports per-instruction-category pass counts for Load/Store, ADD, SUB, SLT, BEQ and BNE.

Parameters:
TIMEOUT, 9, number of consecutive all-zero instructions that signals halt
WATCHDOG, 500, maximum RUN cycles before a forced scan
NUM_WORDS, 22, number of data-memory words swept (word indices 0..NUM_WORDS-1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
inst  in  32  instruction currently fetched by the CPU
cpu_hold  out  1  high in SCAN/DONE; CPU clock-enable must be low while set
mem_addr  out  32  data-memory byte address, idx*4; 0 outside SCAN
mem_rdata  in  32  data-memory word at mem_addr, combinational, big-endian byte order
ref_idx  out  5  reference ROM word index (= idx)
ref_rdata  in  32  reference word at ref_idx, combinational
cnt_ldst/cnt_add/cnt_sub/cnt_beq/cnt_bne  out  3 each  match counts
cnt_slt  out  2  match count
done  out  1  sweep complete
timed_out  out  1  scan triggered by watchdog, not by NOP run
pass  out  1  valid with done; all categorized words matched
first_err_idx  out  5  see Optional Feature
first_err_valid  out  1  see Optional Feature

Behaviour:
- Reset: state RUN; nop_cnt=0, watch_cnt=0, idx=0; all outputs 0.
- FSM states: RUN -> SCAN -> DONE. DONE is held until rst.
- RUN, each edge:
  - nop_cnt = (inst==0) ? nop_cnt+1 : 0
  - watch_cnt increments.
  - Go to SCAN when the updated nop_cnt==TIMEOUT or watch_cnt==WATCHDOG.
  - timed_out=1 only if the watchdog condition is met without the NOP condition. If both occur on the same edge, timed_out=0.
- SCAN:
  - One word per cycle: mem_addr={idx,2'b00} and ref_idx=idx are driven from the idx register.
  - On each edge the word is compared; on a match the matching category counter increments.
  - Category map: idx 3,4,6 LDST; 7-10 ADD; 11-14 BEQ; 15-18 SUB; 19-20 SLT; 21 BNE. All other indices are ignored.
  - After idx=NUM_WORDS-1 is processed, go to DONE. SCAN therefore lasts exactly NUM_WORDS cycles.
- DONE:
  - done=1.
  - pass=1 iff every counter is at its maximum (3,4,4,4,2,1).
  - Counters frozen.
- Counters saturate; they never wrap.
- inst is ignored outside RUN.
- rst in any state returns to the reset condition on the next edge, including mid-SCAN: counters clear and mem_addr returns to 0.

Optional Feature:
Macro CHECKER_MISMATCH_LOG_EN.
- Defined: on the first mismatching categorized word in SCAN, capture idx into first_err_idx and set first_err_valid. Later mismatches do not overwrite. Both clear on rst.
- Undefined: first_err_idx and first_err_valid are tied to 0; no capture logic.

Decomposition:
- Package mips_check_pkg holds:
  - state enum {RUN, SCAN, DONE}
  - category enum {CAT_NONE, LDST, ADD, SUB, SLT, BEQ, BNE}
  - function idx_to_cat
  - per-category expected-count constants
  - counter widths
- Sub-module halt_detector (nop_cnt, watch_cnt, halt/timed_out pulse) is natural. The top keeps the FSM, scan index and scoreboard.

Test Plan:
1. 5 nonzero inst, then 9 zeros; memory equals ROM -> SCAN entered on 9th zero edge; done 22 cycles later; counts 3/4/4/4/2/1; pass=1; timed_out=0.
2. inst never 0 -> SCAN entered on edge 500; timed_out=1; sweep still completes with done=1.
3. 8 zeros, one nonzero, then 9 zeros -> no SCAN after first run; SCAN on 9th zero of second run.
4. Words 8 and 20 corrupted -> cnt_add=3, cnt_slt=1, pass=0; with CHECKER_MISMATCH_LOG_EN, first_err_idx=8 and first_err_valid=1.
5. Words 0,1,2,5 corrupted -> all counts at maximum, pass=1.
6. rst asserted at idx=10 in SCAN -> next cycle: state RUN, mem_addr=0, all counters 0, cpu_hold=0, done=0.
